// File: rtl/config_pkg.sv
// Shared FSM encoding and default geometry for the configuration scrubber.
package config_pkg;
   localparam int NREG_DEF     = 13;
   localparam int REG_W_DEF    = 8;
   localparam int HALF_DIV_DEF = 4;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CRST  = 3'd1,
      S_SHIFT = 3'd2,
      S_CAPT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;
endpackage

// File: rtl/sck_gen.sv
// Serial clock divider: half-period end strobe and p_sck phase, idle-low when disabled.
module sck_gen #(
   parameter int HALF_DIV = 4
) (
   input  logic clkin,
   input  logic rst,
   input  logic i_en,
   output logic o_half_end,
   output logic o_phase
);
   localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

   logic [CW-1:0] r_cnt;
   logic          r_phase;

   assign o_half_end = i_en && (r_cnt == CW'(HALF_DIV - 1));
   assign o_phase    = r_phase;

   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_phase <= 1'b0;
      end else if (!i_en) begin
         r_cnt   <= '0;
         r_phase <= 1'b0;
      end else if (o_half_end) begin
         r_cnt   <= '0;
         r_phase <= ~r_phase;
      end else begin
         r_cnt   <= r_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/config_scrubber.sv
// Serial configuration-chain programmer that verifies the chain readback
// against the image written on the previous run.
module config_scrubber
   import config_pkg::*;
#(
   parameter int NREG     = NREG_DEF,
   parameter int REG_W    = REG_W_DEF,
   parameter int HALF_DIV = HALF_DIV_DEF,
   parameter int PERIOD_W = 26
) (
   input  logic                  clkin,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  auto_en,
   input  logic [PERIOD_W-1:0]   period,
   input  logic [NREG*REG_W-1:0] cfg_data,
   input  logic                  p_sdo,
   output logic                  p_sck,
   output logic                  p_sda,
   output logic                  p_scapt,
   output logic                  p_reset,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [15:0]           mismatch_cnt
);
   localparam int TOT = NREG * REG_W;
   localparam int BW  = (TOT > 1) ? $clog2(TOT) : 1;
   localparam int WW  = $clog2(2 * HALF_DIV) + 1;

   state_t             r_state, w_next;
   logic [TOT-1:0]     r_snap, r_shadow, w_img;
   logic               r_shadow_vld;
   logic [BW-1:0]      r_bit;
   logic [WW-1:0]      r_wait;
   logic               r_rst_hold;
   logic [PERIOD_W-1:0] r_acnt;
   logic               r_err;
   logic [15:0]        r_mismatch_cnt;

   logic w_tick, w_half_end, w_phase, w_shift;
   logic w_rise, w_bit_end, w_last_bit, w_wait_end, w_mis;

   // Stream order: bit k of the image is the k-th bit on the wire
   // (register 0 first, MSB first within each register).
   always_comb begin
      w_img = '0;
      for (int k = 0; k < TOT; k++)
         w_img[k] = cfg_data[(k / REG_W) * REG_W + REG_W - 1 - (k % REG_W)];
   end

   sck_gen #(.HALF_DIV(HALF_DIV)) u_sck (
      .clkin      (clkin),
      .rst        (rst),
      .i_en       (w_shift),
      .o_half_end (w_half_end),
      .o_phase    (w_phase)
   );

   assign w_shift    = (r_state == S_SHIFT);
   assign w_rise     = w_shift && w_half_end && !w_phase;
   assign w_bit_end  = w_shift && w_half_end && w_phase;
   assign w_last_bit = (r_bit == BW'(TOT - 1));
   assign w_wait_end = (r_wait == WW'(2 * HALF_DIV - 1));
   assign w_tick     = auto_en && (period != '0) && (r_acnt == period - 1'b1);
   assign w_mis      = w_rise && r_shadow_vld && (p_sdo != r_shadow[r_bit]);

   always_comb begin
      w_next  = r_state;
      busy    = 1'b1;
      done    = 1'b0;
      p_sck   = 1'b0;
      p_sda   = 1'b0;
      p_scapt = 1'b0;
      p_reset = r_rst_hold;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start || w_tick) w_next = S_CRST;
         end
         S_CRST: begin
            // Chain reset only on the first run; afterwards just a one-cycle hop.
            p_reset = r_rst_hold || !r_shadow_vld;
            if (r_shadow_vld || w_wait_end) w_next = S_SHIFT;
         end
         S_SHIFT: begin
            p_sck = w_phase;
            p_sda = r_snap[r_bit];
            if (w_bit_end && w_last_bit) w_next = S_CAPT;
         end
         S_CAPT: begin
            p_scapt = 1'b1;
            if (w_wait_end) w_next = S_DONE;
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_wait       <= '0;
         r_bit        <= '0;
         r_shadow_vld <= 1'b0;
         r_rst_hold   <= 1'b1;
      end else begin
         r_state    <= w_next;
         r_rst_hold <= 1'b0;
         if (r_state != w_next)
            r_wait <= '0;
         else if (r_state == S_CRST || r_state == S_CAPT)
            r_wait <= r_wait + 1'b1;
         if (!w_shift)
            r_bit <= '0;
         else if (w_bit_end)
            r_bit <= r_bit + 1'b1;
         if (r_state == S_CAPT && w_wait_end)
            r_shadow_vld <= 1'b1;
      end
   end

   // Image storage needs no reset: validity is tracked by r_shadow_vld.
   always_ff @(posedge clkin) begin
      if (r_state == S_IDLE && (start || w_tick))
         r_snap <= w_img;
      if (r_state == S_CAPT && w_wait_end)
         r_shadow <= r_snap;
   end

   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         r_err          <= 1'b0;
         r_mismatch_cnt <= '0;
         r_acnt         <= '0;
      end else begin
         r_err <= w_mis;
         if (w_mis && r_mismatch_cnt != 16'hFFFF)
            r_mismatch_cnt <= r_mismatch_cnt + 1'b1;
         if (!auto_en || period == '0 || w_tick)
            r_acnt <= '0;
         else
            r_acnt <= r_acnt + 1'b1;
      end
   end

   assign err          = r_err;
   assign mismatch_cnt = r_mismatch_cnt;
endmodule
